ahb_slave_resp: RTL
===================

# ahb_slave_resp

AHB-Lite responder front end for the AHB-to-APB bridge: the slave-side counterpart of the bench's AHB master driver. It samples address/control on the AHB address phase, decodes the three APB peripheral regions, and pipelines address/data/write for the APB controller. It generates HREADYOUT wait states from the backend ready and a two-cycle ERROR response for illegal transfers.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- clk  in  1  bus clock; all state updates on rising edge
- resetn  in  1  synchronous active-low reset, sampled on rising clk
- hwrite  in  1  1 = write, 0 = read
- hsize  in  3  transfer size; 0/1/2 legal (byte/half/word)
- hburst  in  3  burst type; decoded for nothing, passed as hburst_reg
- htrans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hreadyin  in  1  bus HREADY; address phase is sampled only when 1
- haddr  in  ADDR_W  address
- hwdata  in  DATA_W  write data (data phase)
- hrdata  out  DATA_W  read data = bk_rdata (combinational)
- hreadyout  out  1  slave ready
- hresp  out  2  00 OKAY, 01 ERROR
- bk_ready  in  1  APB controller finished current transfer
- bk_rdata  in  DATA_W  read data from APB controller
- valid  out  1  legal transfer present in current address phase
- tempselx  out  3  one-hot region select of current haddr
- haddr_1, haddr_2  out  ADDR_W  address delayed 1/2 accepted phases
- hwdata_1, hwdata_2  out  DATA_W  write data delayed 1/2 accepted phases
- hwrite_reg, hwrite_reg1  out  1  hwrite delayed 1/2 accepted phases
- hburst_reg  out  3  hburst of last accepted transfer

## Operation
- Region map: 0x8000_0000–0x83FF_FFFF tempselx=001; 0x8400_0000–0x87FF_FFFF 010; 0x8800_0000–0x8BFF_FFFF 100; else 000.
- Active = hreadyin & htrans[1]. Legal = Active & tempselx!=0 & hsize<=2 & aligned (hsize 1: haddr[0]=0; hsize 2: haddr[1:0]=0).
- valid = Legal & resetn & state!=ERR1 (combinational). tempselx combinational from haddr regardless of htrans.
- Illegal = Active & !Legal.
- FSM states IDLE, WAIT, ERR1, ERR2:
  - IDLE: hreadyout=1, hresp=00. Legal→WAIT; Illegal→ERR1; else stay.
  - WAIT (data phase of accepted transfer): hreadyout=bk_ready, hresp=00. bk_ready=0→stay. bk_ready=1: Legal→WAIT, Illegal→ERR1, else IDLE.
  - ERR1: hreadyout=0, hresp=01. Always→ERR2. Address-phase inputs ignored.
  - ERR2: hreadyout=1, hresp=01. Evaluated as IDLE for the next address phase (Legal→WAIT, Illegal→ERR1, else IDLE).
- BUSY/IDLE htrans: no valid; OKAY zero-wait; pipeline still advances if hreadyin=1.
- Pipeline (advance only when hreadyin=1): haddr_1<=haddr, haddr_2<=haddr_1; hwrite_reg<=hwrite, hwrite_reg1<=hwrite_reg; hburst_reg<=hburst; hwdata_1<=hwdata, hwdata_2<=hwdata_1. hreadyin=0 holds all.

## Timing
- Reset (resetn=0 at a rising edge): state=IDLE, hreadyout=1, hresp=00, all pipeline registers 0. Reset wins over any in-progress WAIT/ERR; bk_ready ignored.
- Address phase in cycle N with Legal → WAIT in N+1; hreadyout in N+1 = bk_ready (zero wait if bk_ready already 1).
- Illegal in N → hreadyout=0/hresp=01 in N+1, hreadyout=1/hresp=01 in N+2, OKAY from N+3 unless a new transfer sampled in N+2.
- Back-to-back Legal with bk_ready=1: hreadyout stays 1, one transfer per cycle, valid high every cycle.
- valid and tempselx have zero latency from haddr/htrans; hrdata has zero latency from bk_rdata.

## Test plan
- Reset: resetn=0 one cycle with htrans=2 → hreadyout=1, hresp=00, haddr_1=0, state IDLE next cycle.
- Single write: haddr=0x8000_0010, htrans=2, hwrite=1, hsize=2, then hwdata=0xDEAD_BEEF, bk_ready=0 for 2 cycles then 1 → valid=1, tempselx=001 in cycle N; hreadyout 0,0,1 in N+1..N+3; haddr_1=0x8000_0010, hwdata_1=0xDEAD_BEEF.
- Unmapped read: haddr=0x9000_0000, htrans=2 → valid=0, tempselx=000; next two cycles hreadyout/hresp = 0/01 then 1/01; then 1/00.
- Misaligned: haddr=0x8400_0002, hsize=2 → ERROR two-cycle response; hsize=1 at same address → OKAY, tempselx=010.
- INCR4 burst at 0x8800_0000 (NONSEQ, SEQ×3, +4 each), bk_ready=1 → valid 4 cycles, hreadyout always 1, haddr_2 trails haddr by two cycles, hburst_reg=3.
- Reset mid-WAIT: bk_ready=0, resetn=0 → next cycle hreadyout=1, hresp=00, pipeline cleared.

Source files
------------

// File: rtl/ahb_slave_resp.sv
// AHB-Lite responder front end for the AHB-to-APB bridge: decodes the APB
// regions, qualifies transfers, drives HREADYOUT/HRESP and pipelines
// address, data and direction for the APB controller.
module ahb_slave_resp #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              hwrite,
  input  logic [2:0]        hsize,
  input  logic [2:0]        hburst,
  input  logic [1:0]        htrans,
  input  logic              hreadyin,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic [DATA_W-1:0] hrdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  input  logic              bk_ready,
  input  logic [DATA_W-1:0] bk_rdata,
  output logic              valid,
  output logic [2:0]        tempselx,
  output logic [ADDR_W-1:0] haddr_1,
  output logic [ADDR_W-1:0] haddr_2,
  output logic [DATA_W-1:0] hwdata_1,
  output logic [DATA_W-1:0] hwdata_2,
  output logic              hwrite_reg,
  output logic              hwrite_reg1,
  output logic [2:0]        hburst_reg
);

  // Each APB region is a 64 MB window selected by the top six address bits.
  localparam int unsigned REGION_W = 6;

  localparam logic [1:0] RESP_OKAY  = 2'b00;
  localparam logic [1:0] RESP_ERROR = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR1 = 2'd2,
    S_ERR2 = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [REGION_W-1:0] region;
  logic                active;
  logic                aligned;
  logic                legal;
  logic                illegal;

  assign region = haddr[ADDR_W-1 -: REGION_W];
  assign hrdata = bk_rdata;

  // Region decode, independent of htrans.
  always_comb begin
    tempselx = 3'b000;
    case (region)
      6'h20:   tempselx = 3'b001;
      6'h21:   tempselx = 3'b010;
      6'h22:   tempselx = 3'b100;
      default: tempselx = 3'b000;
    endcase
  end

  // Size/alignment check; sizes above a word are never legal.
  always_comb begin
    aligned = 1'b0;
    case (hsize)
      3'd0:    aligned = 1'b1;
      3'd1:    aligned = ~haddr[0];
      3'd2:    aligned = (haddr[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
  end

  assign active  = hreadyin & htrans[1];
  assign legal   = active & (tempselx != 3'b000) & aligned;
  assign illegal = active & ~legal;
  assign valid   = legal & resetn & (state != S_ERR1);

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and response outputs.
  always_comb begin
    state_nxt = state;
    hreadyout = 1'b1;
    hresp     = RESP_OKAY;
    case (state)
      S_IDLE, S_ERR2: begin
        if (state == S_ERR2) hresp = RESP_ERROR;
        if (legal)        state_nxt = S_WAIT;
        else if (illegal) state_nxt = S_ERR1;
        else              state_nxt = S_IDLE;
      end
      S_WAIT: begin
        hreadyout = bk_ready;
        if (bk_ready) begin
          if (legal)        state_nxt = S_WAIT;
          else if (illegal) state_nxt = S_ERR1;
          else              state_nxt = S_IDLE;
        end
      end
      S_ERR1: begin
        hreadyout = 1'b0;
        hresp     = RESP_ERROR;
        state_nxt = S_ERR2;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/data/direction pipeline, frozen while the bus is stalled.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      haddr_1     <= '0;
      haddr_2     <= '0;
      hwdata_1    <= '0;
      hwdata_2    <= '0;
      hwrite_reg  <= 1'b0;
      hwrite_reg1 <= 1'b0;
      hburst_reg  <= 3'b000;
    end else if (hreadyin) begin
      haddr_1     <= haddr;
      haddr_2     <= haddr_1;
      hwdata_1    <= hwdata;
      hwdata_2    <= hwdata_1;
      hwrite_reg  <= hwrite;
      hwrite_reg1 <= hwrite_reg;
      hburst_reg  <= hburst;
    end
  end

endmodule
